// File: rtl/clock_reset_sequencer_pkg.sv
// Shared clocking definitions: sequencer state encoding, default timing constants
// and a counter-width helper used to size the sequencer's internal counters.
package clock_reset_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_PLL_RESET = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_FILTER    = 3'd2,
        ST_RELEASE   = 3'd3,
        ST_RUN       = 3'd4,
        ST_FAULT     = 3'd5
    } crs_state_e;

    localparam int DEF_N_DOMAINS           = 3;
    localparam int DEF_PLL_RST_CYCLES      = 16;
    localparam int DEF_LOCK_FILTER_CYCLES  = 1024;
    localparam int DEF_RELEASE_GAP_CYCLES  = 8;
    localparam int DEF_LOCK_TIMEOUT_CYCLES = 65536;
    localparam int DEF_MAX_RETRIES         = 3;
    localparam int DEF_CNT_W               = 8;

    // Bits needed to hold 0..max_val, never narrower than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/clock_reset_sequencer_if.sv
// Sequencer status/control bundle: PLL lock and restart in, PLL and domain resets plus status out.
// master = sequencer side, slave = PLL / domain / supervisor side.
interface clock_reset_sequencer_if
    import clock_reset_sequencer_pkg::*;
#(
    parameter int N_DOMAINS = DEF_N_DOMAINS,
    parameter int CNT_W     = DEF_CNT_W
);
    logic                 pll_lock;
    logic                 restart_req;
    logic                 pll_rst;
    logic [N_DOMAINS-1:0] domain_rst_n;
    logic                 ready;
    logic                 fault;
    logic [CNT_W-1:0]     lock_loss_count;

    modport master (
        input  pll_lock, restart_req,
        output pll_rst, domain_rst_n, ready, fault, lock_loss_count
    );

    modport slave (
        output pll_lock, restart_req,
        input  pll_rst, domain_rst_n, ready, fault, lock_loss_count
    );
endinterface

// File: rtl/clock_reset_sequencer_lock_synchronizer.sv
// Two-flop synchroniser bringing the asynchronous PLL lock into the clk domain.
// Latency: two clk edges; no backpressure (level signal).
module lock_synchronizer (
    input  logic clk,
    input  logic rstn,
    input  logic async_in,
    output logic sync_out
);
    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = async_in;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign sync_out = sync_q;
endmodule

// File: rtl/clock_reset_sequencer.sv
// PLL bring-up sequencer: pulses PLL reset, qualifies lock, then releases domain resets in order.
// Latency: all outputs registered, one edge after lock_s/restart_req; no backpressure (status outputs only).
module clock_reset_sequencer
    import clock_reset_sequencer_pkg::*;
#(
    parameter int N_DOMAINS           = DEF_N_DOMAINS,
    parameter int PLL_RST_CYCLES      = DEF_PLL_RST_CYCLES,
    parameter int LOCK_FILTER_CYCLES  = DEF_LOCK_FILTER_CYCLES,
    parameter int RELEASE_GAP_CYCLES  = DEF_RELEASE_GAP_CYCLES,
    parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int MAX_RETRIES         = DEF_MAX_RETRIES,
    parameter int CNT_W               = DEF_CNT_W
) (
    input  logic                    clk,
    input  logic                    rstn,
    clock_reset_sequencer_if.master bus
);
    localparam int REL_SPAN = N_DOMAINS * RELEASE_GAP_CYCLES;
    localparam int RST_W    = cnt_width(PLL_RST_CYCLES);
    localparam int FLT_W    = cnt_width(LOCK_FILTER_CYCLES);
    localparam int REL_W    = cnt_width(REL_SPAN + 1);
    localparam int TO_W     = cnt_width(LOCK_TIMEOUT_CYCLES);
    localparam int RTY_W    = cnt_width(MAX_RETRIES);

    localparam logic [RST_W-1:0] RST_LAST = RST_W'(PLL_RST_CYCLES - 1);
    localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(LOCK_FILTER_CYCLES - 1);
    localparam logic [REL_W-1:0] REL_LAST = REL_W'(REL_SPAN);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [RTY_W-1:0] RTY_LAST = RTY_W'(MAX_RETRIES - 1);

    logic lock_s;
    logic lock_lost;

    crs_state_e           state_q, state_d;
    logic [RST_W-1:0]     rst_cnt_q, rst_cnt_d;
    logic [FLT_W-1:0]     filt_cnt_q, filt_cnt_d;
    logic [REL_W-1:0]     rel_cnt_q, rel_cnt_d;
    logic [TO_W-1:0]      to_cnt_q, to_cnt_d;
    logic [RTY_W-1:0]     retry_q, retry_d;
    logic                 pll_rst_q, pll_rst_d;
    logic [N_DOMAINS-1:0] domain_rst_n_q, domain_rst_n_d;
    logic                 ready_q, ready_d;
    logic                 fault_q, fault_d;
    logic [CNT_W-1:0]     lock_loss_count_q, lock_loss_count_d;

    lock_synchronizer u_lock_sync (
        .clk      (clk),
        .rstn     (rstn),
        .async_in (bus.pll_lock),
        .sync_out (lock_s)
    );

    assign lock_lost = ((state_q == ST_RELEASE) || (state_q == ST_RUN)) && !lock_s;

    always_comb begin
        state_d           = state_q;
        rst_cnt_d         = '0;
        filt_cnt_d        = '0;
        rel_cnt_d         = '0;
        to_cnt_d          = to_cnt_q;
        retry_d           = retry_q;
        lock_loss_count_d = lock_loss_count_q;
        domain_rst_n_d    = '0;

        case (state_q)
            ST_PLL_RESET: begin
                to_cnt_d = '0;
                if (rst_cnt_q == RST_LAST) begin
                    state_d = ST_WAIT_LOCK;
                end else begin
                    rst_cnt_d = rst_cnt_q + RST_W'(1);
                end
            end
            // The timeout spans both acquisition states; a filter dropout does not refund it.
            ST_WAIT_LOCK, ST_FILTER: begin
                to_cnt_d = to_cnt_q + TO_W'(1);
                if ((state_q == ST_FILTER) && lock_s && (filt_cnt_q == FLT_LAST)) begin
                    state_d = ST_RELEASE;
                    retry_d = '0;
                end else if (to_cnt_q == TO_LAST) begin
                    if (retry_q == RTY_LAST) begin
                        state_d = ST_FAULT;
                    end else begin
                        state_d = ST_PLL_RESET;
                        retry_d = retry_q + RTY_W'(1);
                    end
                end else if (lock_s) begin
                    state_d    = ST_FILTER;
                    filt_cnt_d = filt_cnt_q + FLT_W'(1);
                end else begin
                    state_d = ST_WAIT_LOCK;
                end
            end
            ST_RELEASE: begin
                rel_cnt_d = rel_cnt_q + REL_W'(1);
                if (rel_cnt_q == REL_LAST) begin
                    state_d = ST_RUN;
                end
            end
            default: ;
        endcase

        // Lock loss outranks a coincident restart so the event is still counted.
        if (lock_lost) begin
            state_d   = ST_PLL_RESET;
            rel_cnt_d = '0;
            if (lock_loss_count_q != {CNT_W{1'b1}}) begin
                lock_loss_count_d = lock_loss_count_q + CNT_W'(1);
            end
        end else if (bus.restart_req && (state_q != ST_PLL_RESET)) begin
            state_d    = ST_PLL_RESET;
            retry_d    = '0;
            rel_cnt_d  = '0;
            filt_cnt_d = '0;
        end

        pll_rst_d = (state_d == ST_PLL_RESET) || (state_d == ST_FAULT);
        ready_d   = (state_d == ST_RUN);
        fault_d   = (state_d == ST_FAULT);
        for (int i = 0; i < N_DOMAINS; i++) begin
            domain_rst_n_d[i] = (state_d == ST_RUN) ||
                ((state_d == ST_RELEASE) &&
                 (rel_cnt_d >= REL_W'((i + 1) * RELEASE_GAP_CYCLES)));
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q           <= ST_PLL_RESET;
            rst_cnt_q         <= '0;
            filt_cnt_q        <= '0;
            rel_cnt_q         <= '0;
            to_cnt_q          <= '0;
            retry_q           <= '0;
            pll_rst_q         <= 1'b1;
            domain_rst_n_q    <= '0;
            ready_q           <= 1'b0;
            fault_q           <= 1'b0;
            lock_loss_count_q <= '0;
        end else begin
            state_q           <= state_d;
            rst_cnt_q         <= rst_cnt_d;
            filt_cnt_q        <= filt_cnt_d;
            rel_cnt_q         <= rel_cnt_d;
            to_cnt_q          <= to_cnt_d;
            retry_q           <= retry_d;
            pll_rst_q         <= pll_rst_d;
            domain_rst_n_q    <= domain_rst_n_d;
            ready_q           <= ready_d;
            fault_q           <= fault_d;
            lock_loss_count_q <= lock_loss_count_d;
        end
    end

    assign bus.pll_rst         = pll_rst_q;
    assign bus.domain_rst_n    = domain_rst_n_q;
    assign bus.ready           = ready_q;
    assign bus.fault           = fault_q;
    assign bus.lock_loss_count = lock_loss_count_q;
endmodule
